// File: rtl/upcounter_ctrl.sv
// Run/pause/step/clear/mode sequencer driving the hex/BCD up-counter; one clk domain.
// Button edge in cycle t updates state/outputs in cycle t+1; no backpressure, edges outside IDLE/RUN are dropped.
module upcounter_ctrl #(
  parameter int DIV_MAX   = 100_000_000,
  parameter int DIV_W     = 27,
  parameter bit START_RUN = 1'b0
) (
  input  logic       ctrl_clk,
  input  logic       ctrl_rst,
  input  logic       ctrl_btn_run,
  input  logic       ctrl_btn_step,
  input  logic       ctrl_btn_mode,
  input  logic       ctrl_btn_clr,
  output logic       ctrl_en,
  output logic       ctrl_clr,
  output logic       ctrl_select,
  output logic [1:0] ctrl_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  localparam state_t           RST_STATE = START_RUN ? RUN : IDLE;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_MAX - 1);

  state_t           state;
  logic [DIV_W-1:0] div;
  logic             run_saved;
  logic [3:0]       btn;
  logic [3:0]       btn_q;
  logic [3:0]       btn_edge;
  logic             clr_edge, mode_edge, run_edge, step_edge;

  assign btn       = {ctrl_btn_clr, ctrl_btn_mode, ctrl_btn_run, ctrl_btn_step};
  assign btn_edge  = btn & ~btn_q;
  assign clr_edge  = btn_edge[3];
  assign mode_edge = btn_edge[2];
  assign run_edge  = btn_edge[1];
  assign step_edge = btn_edge[0];

  assign ctrl_state = state;

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_rst) begin
      // Loading the live level means a button held through reset is not an edge.
      btn_q       <= btn;
      state       <= RST_STATE;
      div         <= '0;
      run_saved   <= START_RUN;
      ctrl_en     <= 1'b0;
      ctrl_clr    <= 1'b0;
      ctrl_select <= 1'b0;
    end else begin
      btn_q    <= btn;
      ctrl_en  <= 1'b0;
      ctrl_clr <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (clr_edge || mode_edge) begin
            state     <= CLEAR;
            ctrl_clr  <= 1'b1;
            run_saved <= (state == RUN);
            div       <= '0;
            if (!clr_edge) ctrl_select <= ~ctrl_select;
          end else if (run_edge) begin
            state <= (state == RUN) ? IDLE : RUN;
            div   <= '0;
          end else if (step_edge && state == IDLE) begin
            state   <= STEP;
            ctrl_en <= 1'b1;
          end else if (state == RUN) begin
            // Step edges while running fall through here and leave the prescaler untouched.
            if (div == DIV_LAST) begin
              div     <= '0;
              ctrl_en <= 1'b1;
            end else begin
              div <= div + DIV_W'(1);
            end
          end
        end
        STEP: begin
          state <= IDLE;
          div   <= '0;
        end
        CLEAR: begin
          state <= run_saved ? RUN : IDLE;
          div   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upcounter_ctrl.sv
// Scoreboard bench for upcounter_ctrl: expected ctrl_en/ctrl_clr pulse cycles are queued when buttons are driven.
module tb_upcounter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run, btn_step, btn_mode, btn_clr;
  logic       en, clr, sel;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_q[$];
  int clr_q[$];

  upcounter_ctrl #(.DIV_MAX(4), .DIV_W(3), .START_RUN(1'b0)) dut (
    .ctrl_clk      (clk),
    .ctrl_rst      (rst),
    .ctrl_btn_run  (btn_run),
    .ctrl_btn_step (btn_step),
    .ctrl_btn_mode (btn_mode),
    .ctrl_btn_clr  (btn_clr),
    .ctrl_en       (en),
    .ctrl_clr      (clr),
    .ctrl_select   (sel),
    .ctrl_state    (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Returns 1 ns after the edge; inputs driven afterwards are sampled by the next edge.
  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulse monitor: every observed pulse must match the next queued expected cycle.
  always begin
    @(posedge clk);
    #1;
    if (en) begin
      if (en_q.size() == 0) chk("en_unexpected", 32'd1, 32'd0);
      else                  chk("en_cycle", cyc, en_q.pop_front());
    end
    if (clr) begin
      if (clr_q.size() == 0) chk("clr_unexpected", 32'd1, 32'd0);
      else                   chk("clr_cycle", cyc, clr_q.pop_front());
    end
    if (en || clr) chk("en_clr_exclusive", {31'd0, en & clr}, 32'd0);
  end

  initial begin
    int k, m, a, b, c;
    rst = 1'b1; btn_run = 1'b1; btn_step = 1'b0; btn_mode = 1'b0; btn_clr = 1'b0;

    // Reset with run held high
    step_cyc(); step_cyc();
    chk("rst_state", state, 0);
    chk("rst_en", en, 0);
    chk("rst_clr", clr, 0);
    chk("rst_sel", sel, 0);
    rst = 1'b0;
    repeat (4) step_cyc();
    chk("run_held_no_entry", state, 0);
    btn_run = 1'b0;
    step_cyc();

    // Run: pulses every 4 cycles, a step edge while running must not disturb them
    k = cyc;
    btn_run = 1'b1;
    for (int i = 0; i < 5; i++) en_q.push_back(k + 5 + 4 * i);
    step_cyc();
    chk("t2_run", state, 1);
    btn_run = 1'b0;
    while (cyc < k + 7) step_cyc();
    btn_step = 1'b1;
    step_cyc();
    btn_step = 1'b0;
    while (cyc < k + 22) step_cyc();
    btn_run = 1'b1;
    step_cyc();
    chk("t2_pause", state, 0);
    btn_run = 1'b0;
    repeat (8) step_cyc();
    chk("t2_pulses_done", en_q.size(), 0);

    // Single steps from IDLE
    for (int n = 0; n < 3; n++) begin
      m = cyc;
      btn_step = 1'b1;
      en_q.push_back(m + 1);
      step_cyc();
      chk("t3_step_state", state, 2);
      btn_step = 1'b0;
      step_cyc();
      chk("t3_back_idle", state, 0);
      repeat (3) step_cyc();
    end
    chk("t3_pulses_done", en_q.size(), 0);

    // Mode change while running
    a = cyc;
    btn_run = 1'b1;
    en_q.push_back(a + 5);
    step_cyc();
    btn_run = 1'b0;
    while (cyc < a + 6) step_cyc();
    btn_mode = 1'b1;
    clr_q.push_back(a + 7);
    en_q.push_back(a + 12);
    en_q.push_back(a + 16);
    step_cyc();
    chk("t4_clear_state", state, 3);
    chk("t4_select", sel, 1);
    btn_mode = 1'b0;
    step_cyc();
    chk("t4_rerun", state, 1);
    while (cyc < a + 17) step_cyc();
    btn_run = 1'b1;
    step_cyc();
    chk("t4_pause", state, 0);
    btn_run = 1'b0;
    repeat (6) step_cyc();
    chk("t4_en_done", en_q.size(), 0);
    chk("t4_clr_done", clr_q.size(), 0);

    // Clear and run edges together in IDLE: clear wins
    b = cyc;
    btn_clr = 1'b1;
    btn_run = 1'b1;
    clr_q.push_back(b + 1);
    step_cyc();
    chk("t5_clear_state", state, 3);
    btn_clr = 1'b0;
    btn_run = 1'b0;
    step_cyc();
    chk("t5_idle", state, 0);
    chk("t5_select_kept", sel, 1);
    repeat (8) step_cyc();
    chk("t5_still_idle", state, 0);
    chk("t5_clr_done", clr_q.size(), 0);

    // Reset mid-run with prescaler at 2
    c = cyc;
    btn_run = 1'b1;
    step_cyc();
    btn_run = 1'b0;
    step_cyc(); step_cyc();
    chk("t6_running", state, 1);
    chk("t6_select_before", sel, 1);
    rst = 1'b1;
    step_cyc();
    chk("t6_state", state, 0);
    chk("t6_en", en, 0);
    chk("t6_clr", clr, 0);
    chk("t6_select", sel, 0);
    rst = 1'b0;
    repeat (8) step_cyc();
    chk("t6_idle", state, 0);
    chk("t6_en_done", en_q.size(), 0);
    chk("t6_start_cycle", cyc - c, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
